vga_timing_gen: RTL

Raster timing generator for the 640x480 @ 60 Hz display path. Runs the horizontal and vertical counters and drives pixelX/pixelY to the drawing modules (background, objects, mux). It takes back the registered 8-bit RGB332 colour they return and emits latency-aligned VGA sync, blanking and 4-bit-per-channel colour to the DAC pins. It is the source end of the pixelX/pixelY → RGB interface.

---
 rtl/vga_timing_gen_pkg.sv | 26 ++
 rtl/vga_timing_gen_if.sv | 12 +
 rtl/vga_timing_gen_delay_line.sv | 22 ++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: 640x480@60 timing constants, RGB332 pixel type and 4-bit-per-channel expansion
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  // Replicate MSBs so full-scale input maps to full-scale DAC code.
  function automatic logic [11:0] rgb332_to_444(rgb332_t c);
    return {c.r, c.r[2], c.g, c.g[2], c.b, c.b};
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel coordinate -> colour bus between the timing generator and drawing modules
//   master (timing gen): drives pixelX/pixelY/startOfFrame, receives RGB_in
//   slave (drawing mux): receives coordinates, returns RGB_in PIPE_DELAY clocks later
interface vga_timing_gen_if;
  import vga_pkg::*;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic startOfFrame;
  rgb332_t RGB_in;
  modport master(output pixelX, pixelY, startOfFrame, input RGB_in);
  modport slave(input pixelX, pixelY, startOfFrame, output RGB_in);
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// vga_delay_line: DEPTH-stage shift register of WIDTH bits, async active-low reset to RESET_VAL
//   clk, resetN: clock / async reset; d_i: input word; q_o: word delayed DEPTH clocks
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters for 640x480@60 plus latency-aligned sync/blank/colour to the DAC
//   clk, resetN: pixel clock / async active-low reset
//   testMode: colour-bar select (only with VGA_TEST_PATTERN_EN defined)
//   pix (master): pixelX/pixelY/startOfFrame out, RGB332 colour back PIPE_DELAY clocks later
//   hsyncN, vsyncN, blankN, vgaR/G/B: DAC side, PIPE_DELAY+1 clocks behind pixelX/pixelY
//   Build option: VGA_TEST_PATTERN_EN adds the 64-pixel colour-bar generator.
module vga_timing_gen import vga_pkg::*; #(
  parameter int PIPE_DELAY = 1,
  parameter int H_ACT = vga_pkg::H_ACTIVE,
  parameter int H_FRONT = vga_pkg::H_FP,
  parameter int H_PULSE = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BP,
  parameter int V_ACT = vga_pkg::V_ACTIVE,
  parameter int V_FRONT = vga_pkg::V_FP,
  parameter int V_PULSE = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BP
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              testMode,
  vga_timing_gen_if.master  pix,
  output logic              hsyncN,
  output logic              vsyncN,
  output logic              blankN,
  output logic [3:0]        vgaR,
  output logic [3:0]        vgaG,
  output logic [3:0]        vgaB
);
  localparam logic [10:0] X_LAST = 11'(H_ACT + H_FRONT + H_PULSE + H_BACK - 1);
  localparam logic [10:0] Y_LAST = 11'(V_ACT + V_FRONT + V_PULSE + V_BACK - 1);
  localparam logic [10:0] X_ACT = 11'(H_ACT);
  localparam logic [10:0] Y_ACT = 11'(V_ACT);
  localparam logic [10:0] HS_ON = 11'(H_ACT + H_FRONT);
  localparam logic [10:0] HS_OFF = 11'(H_ACT + H_FRONT + H_PULSE);
  localparam logic [10:0] VS_ON = 11'(V_ACT + V_FRONT);
  localparam logic [10:0] VS_OFF = 11'(V_ACT + V_FRONT + V_PULSE);
`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = 6;
`else
  localparam int DW = 3;
`endif
  logic [10:0] x_q, x_d, y_q, y_d;
  logic sof_q, sof_d;
  logic active, in_hs, in_vs;
  logic [DW-1:0] dl_d, dl_q;
  rgb332_t src;
  logic hsync_n_q, vsync_n_q, blank_n_q;
  logic [11:0] rgb_q;
  always_comb begin
    x_d = (x_q == X_LAST) ? '0 : x_q + 11'd1;
    y_d = (x_q != X_LAST) ? y_q : (y_q == Y_LAST) ? '0 : y_q + 11'd1;
    sof_d = (x_q == X_LAST) && (y_q == Y_LAST);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      x_q <= '0;
      y_q <= '0;
      sof_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      sof_q <= sof_d;
    end
  assign pix.pixelX = x_q;
  assign pix.pixelY = y_q;
  assign pix.startOfFrame = sof_q;
  assign active = (x_q < X_ACT) && (y_q < Y_ACT);
  assign in_hs = (x_q >= HS_ON) && (x_q < HS_OFF);
  assign in_vs = (y_q >= VS_ON) && (y_q < VS_OFF);
`ifdef VGA_TEST_PATTERN_EN
  // Only pixelX[8:6] selects a bar, so only those bits ride the delay line.
  assign dl_d = {active, in_hs, in_vs, x_q[8:6]};
  assign src = testMode ? rgb332_t'({dl_q[2:0], dl_q[2:0], dl_q[1:0]}) : pix.RGB_in;
`else
  logic unused_test_mode;
  assign unused_test_mode = testMode;
  assign dl_d = {active, in_hs, in_vs};
  assign src = pix.RGB_in;
`endif
  vga_delay_line #(.WIDTH(DW), .DEPTH(PIPE_DELAY), .RESET_VAL('0)) u_dly (
    .clk    (clk),
    .resetN (resetN),
    .d_i    (dl_d),
    .q_o    (dl_q)
  );
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hsync_n_q <= !dl_q[DW-2];
      vsync_n_q <= !dl_q[DW-3];
      blank_n_q <= dl_q[DW-1];
      rgb_q <= dl_q[DW-1] ? rgb332_to_444(src) : '0;
    end
  assign hsyncN = hsync_n_q;
  assign vsyncN = vsync_n_q;
  assign blankN = blank_n_q;
  assign {vgaR, vgaG, vgaB} = rgb_q;
endmodule
